// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: host command codes, the FSM
// state encoding and the word/byte geometry used by the packer.
package loader_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_DUMP_D = 8'h03;
    localparam logic [7:0] CMD_RUN    = 8'h04;
    localparam logic [7:0] CMD_STOP   = 8'h05;

    // Bytes carried per memory word on the byte stream
    localparam int BYTES_PER_WORD = 4;

    // FSM state encoding; IDLE is zero so a cleared state register is IDLE
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_CNT_HI    = 4'd1;
    localparam logic [3:0] ST_CNT_LO    = 4'd2;
    localparam logic [3:0] ST_LOAD      = 4'd3;
    localparam logic [3:0] ST_WRITE     = 4'd4;
    localparam logic [3:0] ST_DUMP_RD   = 4'd5;
    localparam logic [3:0] ST_DUMP_WAIT = 4'd6;
    localparam logic [3:0] ST_DUMP_TX   = 4'd7;
    localparam logic [3:0] ST_RUN       = 4'd8;

    // Byte address of a word index
    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte-stream bus of the program loader.
//   s_data/s_valid/s_ready : host -> loader command and payload bytes
//   m_data/m_valid/m_ready : loader -> host dump bytes
// Handshake: a byte moves on a rising clk edge where valid and ready are both
// high; the sender holds data stable while valid=1 and ready=0, and valid
// never depends combinationally on ready.
interface program_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output s_data, s_valid, m_ready,
                    input  s_ready, m_data, m_valid);
    modport slave  (input  s_data, s_valid, m_ready,
                    output s_ready, m_data, m_valid);
endinterface

// File: rtl/word_packer.sv
// Byte <-> word shifter shared by the load and dump paths.
//   shift    : shift word left one byte, byte_in enters at the bottom
//   load     : parallel load of word_in (has priority over shift)
//   word     : current word register
//   byte_out : most significant byte, i.e. the next byte to transmit
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    input  logic        load,
    input  logic [31:0] word_in,
    output logic [31:0] word,
    output logic [7:0]  byte_out
);
    localparam int W = 8 * BYTES_PER_WORD;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            word <= '0;
        end else if (load) begin
            word <= word_in;
        end else if (shift) begin
            word <= {word[W-9:0], byte_in};
        end
    end

    assign byte_out = word[W-1:W-8];
endmodule

// File: rtl/program_loader.sv
// Program loader: decodes a host byte stream to fill the instruction and data
// memories through their external ports, dump data memory back to the host,
// and start/stop the CPU.
//   clk, arst          : clock, asynchronous active-high reset
//   bus                : host byte stream (slave side)
//   addr/wdata/wen/ren_ext       : instruction memory external port
//   addr/wdata/wen/ren_ext_2     : data memory external port, rdata_ext_2
//                                  valid the cycle after ren_ext_2
//   enable             : CPU run enable (high only in RUN)
//   busy               : high outside IDLE and RUN
//   err                : sticky error (unknown command, count > depth)
//   state_dbg          : current FSM state
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    arst,
    program_loader_if.slave         bus,
    output logic [31:0]             addr_ext,
    output logic [31:0]             wdata_ext,
    output logic                    wen_ext,
    output logic                    ren_ext,
    output logic [31:0]             addr_ext_2,
    output logic [31:0]             wdata_ext_2,
    output logic                    wen_ext_2,
    output logic                    ren_ext_2,
    input  logic [31:0]             rdata_ext_2,
    output logic                    enable,
    output logic                    busy,
    output logic                    err,
    output logic [3:0]              state_dbg
);
    logic [3:0]  state;
    logic [7:0]  cmd;
    logic [15:0] count;
    logic [15:0] done;
    logic [15:0] index;
    logic [1:0]  byte_cnt;

    logic        s_fire, m_fire;
    logic [16:0] depth_sel;
    logic [15:0] last_index, next_index, new_count;
    logic        last_word, last_byte;
    logic        pk_shift, pk_load;
    logic [7:0]  pk_byte_in, pk_byte_out;
    logic [31:0] pk_word;

    assign s_fire = bus.s_valid && bus.s_ready;
    assign m_fire = bus.m_valid && bus.m_ready;

    // LOAD_I targets IMEM; LOAD_D and DUMP_D both target DMEM
    assign depth_sel  = (cmd == CMD_LOAD_I) ? 17'(IMEM_DEPTH) : 17'(DMEM_DEPTH);
    assign last_index = 16'(depth_sel - 17'd1);
    assign next_index = (index == last_index) ? 16'd0 : index + 16'd1;
    assign new_count  = {count[15:8], bus.s_data};
    assign last_word  = (done + 16'd1 == count);
    assign last_byte  = (byte_cnt == 2'(BYTES_PER_WORD - 1));

    assign pk_shift   = (state == ST_LOAD && s_fire) || (state == ST_DUMP_TX && m_fire);
    assign pk_byte_in = (state == ST_LOAD) ? bus.s_data : 8'h00;
    assign pk_load    = (state == ST_DUMP_WAIT);

    word_packer u_packer (
        .clk      (clk),
        .arst     (arst),
        .shift    (pk_shift),
        .byte_in  (pk_byte_in),
        .load     (pk_load),
        .word_in  (rdata_ext_2),
        .word     (pk_word),
        .byte_out (pk_byte_out)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            count     <= '0;
            done      <= '0;
            index     <= '0;
            byte_cnt  <= '0;
            err       <= 1'b0;
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            ren_ext_2 <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses raised on entry to WRITE / DUMP_RD
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            ren_ext_2 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_fire) begin
                        case (bus.s_data)
                            CMD_LOAD_I, CMD_LOAD_D, CMD_DUMP_D: begin
                                cmd   <= bus.s_data;
                                count <= '0;
                                done  <= '0;
                                index <= '0;
                                state <= ST_CNT_HI;
                            end
                            CMD_RUN:  state <= ST_RUN;
                            CMD_STOP: state <= ST_IDLE;
                            default:  err   <= 1'b1;
                        endcase
                    end
                end
                ST_CNT_HI: begin
                    if (s_fire) begin
                        count[15:8] <= bus.s_data;
                        state       <= ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (s_fire) begin
                        count    <= new_count;
                        byte_cnt <= '0;
                        // Oversized counts still run to completion, wrapping the index
                        if ({1'b0, new_count} > depth_sel) err <= 1'b1;
                        if (new_count == 16'd0) begin
                            state <= ST_IDLE;
                        end else if (cmd == CMD_DUMP_D) begin
                            state     <= ST_DUMP_RD;
                            ren_ext_2 <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (s_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            state     <= ST_WRITE;
                            wen_ext   <= (cmd == CMD_LOAD_I);
                            wen_ext_2 <= (cmd == CMD_LOAD_D);
                        end
                    end
                end
                ST_WRITE: begin
                    index <= next_index;
                    done  <= done + 16'd1;
                    state <= last_word ? ST_IDLE : ST_LOAD;
                end
                ST_DUMP_RD:   state <= ST_DUMP_WAIT;
                ST_DUMP_WAIT: begin
                    byte_cnt <= '0;
                    state    <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (m_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            index <= next_index;
                            done  <= done + 16'd1;
                            if (last_word) begin
                                state <= ST_IDLE;
                            end else begin
                                state     <= ST_DUMP_RD;
                                ren_ext_2 <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    // Everything but STOP is swallowed while the CPU runs
                    if (s_fire && bus.s_data == CMD_STOP) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address and data come straight from registers; only the strobes qualify them
    assign addr_ext    = word_addr(index);
    assign addr_ext_2  = word_addr(index);
    assign wdata_ext   = pk_word;
    assign wdata_ext_2 = pk_word;
    assign ren_ext     = 1'b0;

    assign bus.s_ready = (state == ST_IDLE) || (state == ST_CNT_HI) || (state == ST_CNT_LO) ||
                         (state == ST_LOAD) || (state == ST_RUN);
    assign bus.m_valid = (state == ST_DUMP_TX);
    assign bus.m_data  = pk_byte_out;
    assign enable      = (state == ST_RUN);
    assign busy        = !((state == ST_IDLE) || (state == ST_RUN));
    assign state_dbg   = state;
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CHI  = 4'd1;
    localparam logic [3:0] S_CLO  = 4'd2;
    localparam logic [3:0] S_LOAD = 4'd3;
    localparam logic [3:0] S_RUN  = 4'd8;
    localparam int W = 72;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    program_loader_if bus ();

    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext_2 = '0;
    logic        enable, busy, err;
    logic [3:0]  state_dbg;

    program_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
        .clk         (clk),
        .arst        (arst),
        .bus         (bus),
        .addr_ext    (addr_ext),
        .wdata_ext   (wdata_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .addr_ext_2  (addr_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .enable      (enable),
        .busy        (busy),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // ---------------- data memory model ----------------
    bit [31:0]   dmem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_fail = 0;
    int clash = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_log[$];
    logic [7:0]   rx_q[$];

    // Observe strobes and dump bytes mid-cycle; a byte seen with valid&ready
    // here is the one taken on the following rising edge.
    always @(negedge clk) begin
        if (wen_ext)   wr_log.push_back({8'h01, addr_ext, wdata_ext});
        if (wen_ext_2) wr_log.push_back({8'h02, addr_ext_2, wdata_ext_2});
        if (int'(wen_ext) + int'(wen_ext_2) + int'(ren_ext_2) + int'(ren_ext) > 1) clash++;
        if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, W'(wr_log.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check(name, wr_log[i], exp_q[i]);
        wr_log.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, state %h", b, state_dbg);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (state_dbg !== S_IDLE && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: state %h never returned to idle", name, state_dbg);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check({name, "_addr"}, W'({addr_ext, addr_ext_2}), '0);
        check({name, "_wdata"}, W'({wdata_ext, wdata_ext_2}), '0);
        check({name, "_ctl"},
              W'({bus.m_valid, bus.m_data, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                  enable, busy, err, state_dbg, bus.s_ready}),
              W'(1'b1));
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // ---------------- table ----------------
    typedef struct packed {
        logic [7:0] din;
        logic [3:0] st;
        logic       en;
        logic       bsy;
        logic       er;
        logic       rdy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int t;
        logic [31:0] w;

        tbl[0]  = '{8'h04, S_RUN,  1'b1, 1'b0, 1'b0, 1'b1}; // RUN
        tbl[1]  = '{8'h01, S_RUN,  1'b1, 1'b0, 1'b0, 1'b1}; // LOAD_I ignored in RUN
        tbl[2]  = '{8'h7F, S_RUN,  1'b1, 1'b0, 1'b0, 1'b1}; // junk ignored in RUN, no err
        tbl[3]  = '{8'h05, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1}; // STOP
        tbl[4]  = '{8'h01, S_CHI,  1'b0, 1'b1, 1'b0, 1'b1}; // LOAD_I
        tbl[5]  = '{8'h00, S_CLO,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{8'h00, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1}; // N=0
        tbl[7]  = '{8'h7F, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1}; // bad command
        tbl[8]  = '{8'h01, S_CHI,  1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, S_CLO,  1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{8'h00, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1}; // N=0 after error

        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        do_reset("reset_initial");

        for (int i = 0; i < 11; i++) begin
            send_byte(tbl[i].din);
            check($sformatf("table_%0d", i),
                  W'({state_dbg, enable, busy, err, bus.s_ready}),
                  W'({tbl[i].st, tbl[i].en, tbl[i].bsy, tbl[i].er, tbl[i].rdy}));
        end
        check_log("table_no_access");

        // Load two instruction words after RUN/STOP and a bad command
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_word(32'h20080005);
        send_word(32'h2009000A);
        wait_idle("load_i");
        exp_q.push_back({8'h01, 32'h0000_0000, 32'h20080005});
        exp_q.push_back({8'h01, 32'h0000_0004, 32'h2009000A});
        check_log("load_i");
        check("load_busy_err", W'({busy, err}), W'(2'b01));

        // Dump two DMEM words with back-pressure
        do_reset("reset_pre_dump");
        preload(10'd1, 32'hDEADBEEF);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h02);
        t = 0;
        while (!bus.m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 3; k++) begin
            check("dump_stall_first", W'({bus.m_valid, bus.m_data}), W'({1'b1, 8'h00}));
            @(negedge clk);
        end
        @(posedge clk); #2 bus.m_ready = 1'b1;
        t = 0;
        while (rx_q.size() < 5 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #2 bus.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dump_stall_mid", W'({bus.m_valid, bus.m_data}), W'({1'b1, 8'hAD}));
        end
        @(posedge clk); #2 bus.m_ready = 1'b1;
        wait_idle("dump");
        @(negedge clk);
        bus.m_ready = 1'b0;
        w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) exp_q.push_back(W'(8'h00));
        for (int k = 3; k >= 0; k--) exp_q.push_back(W'(w[8*k +: 8]));
        check("dump_count", W'(rx_q.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("dump_byte_%0d", i), W'(rx_q[i]), exp_q[i]);
        exp_q.delete();
        rx_q.delete();
        check_log("dump_no_write");
        check("dump_err", W'({busy, err}), W'(2'b00));

        // Reset in the middle of a load payload
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        check("midload_state", W'(state_dbg), W'(S_LOAD));
        do_reset("reset_midload");
        repeat (3) @(negedge clk);
        check_log("midload_no_write");
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_word(32'hA5A50F0F);
        wait_idle("post_reset_load");
        exp_q.push_back({8'h01, 32'h0000_0000, 32'hA5A50F0F});
        check_log("post_reset_load");

        // DMEM overflow: 1025 words into a 1024-word memory wraps to address 0
        send_byte(8'h02); send_byte(8'h04); send_byte(8'h01);
        check("ovf_err_at_count", W'({state_dbg, err}), W'({S_LOAD, 1'b1}));
        for (int i = 0; i < 1025; i++) send_word(32'h5A00_0000 | 32'(i));
        wait_idle("overflow");
        for (int i = 0; i < 1025; i++)
            exp_q.push_back({8'h02, 32'((i % 1024) * 4), 32'h5A00_0000 | 32'(i)});
        check_log("overflow");
        check("ovf_dmem0", W'(dmem[0]), W'(32'h5A00_0400));
        check("ovf_final", W'({busy, err, enable}), W'(3'b010));

        check("strobe_exclusive", W'(clash), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 512, instruction memory depth in words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 1024, data memory depth in words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  8  host command/payload byte.
REQ-006 s_valid / s_ready  input / output  1 / 1  byte handshake; transfer when both are high at a clk edge.
REQ-007 m_data  output  8  dump byte to host.
REQ-008 m_valid / m_ready  output / input  1 / 1  dump handshake; transfer when both are high.
REQ-009 addr_ext, wdata_ext  output  32 each  instruction memory external port address and write data.
REQ-010 wen_ext, ren_ext  output  1 each  instruction memory external port write and read enables; ren_ext is tied 0.
REQ-011 addr_ext_2, wdata_ext_2  output  32 each  data memory external port address and write data.
REQ-012 wen_ext_2, ren_ext_2  output  1 each  data memory external port write and read enables.
REQ-013 rdata_ext_2  input  32  data memory read word, valid the cycle after ren_ext_2 is asserted.
REQ-014 enable  output  1  CPU run enable.
REQ-015 busy  output  1  high in any state other than IDLE and RUN.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 Command byte values: 0x01 = LOAD_I, 0x02 = LOAD_D, 0x03 = DUMP_D, 0x04 = RUN, 0x05 = STOP.
REQ-018 Command framing: LOAD_I, LOAD_D and DUMP_D are followed by a 16-bit word count N, most significant byte first; the loads are then followed by 4*N payload bytes, each word most significant byte first.
REQ-019 FSM states and transitions: IDLE -> CNT_HI -> CNT_LO -> (LOAD | DUMP_RD | IDLE); LOAD <-> WRITE; DUMP_RD -> DUMP_WAIT -> DUMP_TX; IDLE <-> RUN.
REQ-020 s_ready SHALL be high in IDLE, CNT_HI, CNT_LO, LOAD and RUN, and low in all other states.
REQ-021 In LOAD, 4 accepted bytes SHALL be shifted into a word register; after the 4th byte the FSM enters WRITE for exactly 1 cycle.
REQ-022 In WRITE, the FSM SHALL assert the selected wen for 1 cycle with addr = 4*index and wdata = the assembled word, then increment index.
REQ-023 After the Nth write the FSM SHALL return to IDLE.
REQ-024 Word index SHALL start at 0 on each command and wrap modulo the selected depth; a count N greater than the selected depth SHALL set err, and the load SHALL still consume all payload bytes.
REQ-025 N = 0 SHALL perform no memory access and SHALL return to IDLE after CNT_LO.
REQ-026 DUMP_D: for each index, DUMP_RD SHALL assert ren_ext_2 for 1 cycle at addr_ext_2 = 4*index, and DUMP_WAIT SHALL capture rdata_ext_2.
REQ-027 DUMP_TX SHALL send the captured word as 4 bytes, most significant byte first, holding m_data stable while m_valid=1 and m_ready=0.
REQ-028 An unknown command byte SHALL set err and leave the FSM in IDLE.
REQ-029 RUN command: enable SHALL go high on the cycle after acceptance and the FSM enters RUN.
REQ-030 In RUN, only STOP is honoured: STOP clears enable on the next cycle and returns to IDLE; other bytes are accepted and discarded without setting err.
REQ-031 enable SHALL be 0 in every state except RUN, so memories are never written while the CPU runs.
REQ-032 All memory strobes SHALL be registered outputs with at most one asserted per cycle.

Reset
REQ-033 While arst is high the FSM SHALL be in IDLE.
REQ-034 While arst is high all outputs SHALL be 0, except s_ready = 1; err, index, count and the word register SHALL be cleared.
REQ-035 arst mid-LOAD or mid-DUMP SHALL abort the transfer immediately, with no partial write.

Structure
REQ-036 Command codes, FSM state encoding and the 4-byte-per-word constant SHALL live in a shared package loader_pkg.
REQ-037 The byte-to-word / word-to-byte shifter SHALL be one sub-module, word_packer, reused for LOAD and DUMP.

Verification
REQ-038 Load: LOAD_I, N=2, payload 20080005 2009000A -> wen_ext pulses at addr 0x0 and 0x4 with those words, then busy=0.
REQ-039 Dump: preload DMEM[1]=0xDEADBEEF, send DUMP_D N=2 starting at index 0; hold m_ready low for 3 cycles -> bytes 00 00 00 00 DE AD BE EF, m_data stable while stalled.
REQ-040 Overflow: LOAD_D with N=1025 -> err=1 and word 1024 written at addr 0x0 (wrap).
REQ-041 Run/stop: RUN -> enable=1 the next cycle; then LOAD_I byte -> enable stays 1; then STOP -> enable=0 and a subsequent LOAD works.
REQ-042 Reset: assert arst after 2 payload bytes of LOAD_I -> no wen_ext pulse, FSM in IDLE; next command decoded correctly.
REQ-043 Bad command: byte 0x7F -> err=1, s_ready stays 1, following LOAD_I N=0 returns to IDLE with no memory access.
